// File: rtl/rng_pkg.sv
// Shared types and constants for the roll-history display path.
package rng_pkg;

  // Width of one generator roll result, shared with the lab1 generator.
  localparam int unsigned RNG_WIDTH = 4;

  // Browse state of the history viewer.
  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    LIVE   = 2'd1,
    BROWSE = 2'd2
  } hist_state_t;

endpackage

// File: rtl/rng_history_if.sv
// Roll-capture and browse bus between the key/generator side and the history block.
interface rng_history_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = rng_pkg::RNG_WIDTH
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] i_value;
  logic             i_done;
  logic             i_prev;
  logic             i_next;
  logic [WIDTH-1:0] o_display;
  logic [AW-1:0]    o_index;
  logic [AW:0]      o_count;
  logic             o_empty;
  logic [WIDTH-1:0] o_max;

  // Stimulus side: generator, debounced keys, display consumer.
  modport master (
    output i_value, i_done, i_prev, i_next,
    input  o_display, o_index, o_count, o_empty, o_max
  );

  // History block side.
  modport slave (
    input  i_value, i_done, i_prev, i_next,
    output o_display, o_index, o_count, o_empty, o_max
  );
endinterface

// File: rtl/rng_history_mem.sv
// History storage: one write port, one registered read port with synchronous clear.
module rng_history_mem #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  input  logic                     rclr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Array contents are never reset; unreachable entries are masked by the count.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; rclr forces zero while nothing valid is selected.
  always_ff @(posedge clk) begin
    if (rclr) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/rng_history.sv
// Circular history of finished rolls with prev/next browsing for the display.
// Optional running maximum enabled by defining RNG_HISTORY_MAX_EN.
module rng_history
  import rng_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = RNG_WIDTH
) (
  input  logic          i_clk,
  input  logic          i_rst,
  rng_history_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  hist_state_t   state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] idx;
  logic [CW-1:0] cnt;
  logic          empty;
  logic [AW-1:0] rd_addr;
  logic          rd_clr;
  logic          prev_only;
  logic          next_only;

  // Simultaneous prev+next cancel each other out.
  assign prev_only = bus.i_prev & ~bus.i_next;
  assign next_only = bus.i_next & ~bus.i_prev;

  // Newest entry sits just below the write pointer; browse offset walks back from it.
  assign rd_addr = wr_ptr - AW'(1) - idx;
  assign rd_clr  = i_rst | (state == EMPTY);

  // Browse FSM with pointers and count; a finished roll always wins over browsing.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= EMPTY;
      wr_ptr <= '0;
      cnt    <= '0;
      idx    <= '0;
      empty  <= 1'b1;
    end else if (bus.i_done) begin
      wr_ptr <= wr_ptr + AW'(1);
      if (cnt != CW'(DEPTH)) begin
        cnt <= cnt + CW'(1);
      end
      idx   <= '0;
      empty <= 1'b0;
      state <= LIVE;
    end else begin
      case (state)
        EMPTY: begin
          idx <= '0;
        end
        LIVE: begin
          if (prev_only && (cnt >= CW'(2))) begin
            idx   <= AW'(1);
            state <= BROWSE;
          end
        end
        BROWSE: begin
          if (prev_only) begin
            if (CW'(idx) < (cnt - CW'(1))) begin
              idx <= idx + AW'(1);
            end
          end else if (next_only) begin
            idx <= idx - AW'(1);
            if (idx == AW'(1)) begin
              state <= LIVE;
            end
          end
        end
        default: begin
          state <= EMPTY;
          idx   <= '0;
        end
      endcase
    end
  end

  rng_history_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk   (i_clk),
    .we    (bus.i_done),
    .waddr (wr_ptr),
    .wdata (bus.i_value),
    .raddr (rd_addr),
    .rclr  (rd_clr),
    .rdata (bus.o_display)
  );

  assign bus.o_index = idx;
  assign bus.o_count = cnt;
  assign bus.o_empty = empty;

`ifdef RNG_HISTORY_MAX_EN
  logic [WIDTH-1:0] max_val;

  // Running maximum of every pushed roll; only reset lowers it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      max_val <= '0;
    end else if (bus.i_done && (bus.i_value > max_val)) begin
      max_val <= bus.i_value;
    end
  end

  assign bus.o_max = max_val;
`else
  assign bus.o_max = '0;
`endif

endmodule

// File: tb/tb_rng_history.sv
// Self-checking bench for rng_history: queue model of the history plus directed checks.
module tb_rng_history;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned WIDTH = 4;

  typedef struct {
    logic [3:0] disp;
    logic [2:0] idx;
    logic [3:0] cnt;
    logic       empty;
    logic [3:0] max;
  } exp_t;

  logic clk;
  logic rst;

  rng_history_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  rng_history #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int ncomp = 0;
  int nfail = 0;

  exp_t       sb[$];
  logic [3:0] hist[$];
  int         midx = 0;
  int         mstate = 0;
  logic [3:0] mmax = 4'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, predict outputs, then compare after the edge.
  task automatic step(input logic r, input logic d, input logic [3:0] v,
                      input logic p, input logic n);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst = r;
    bus.i_done = d;
    bus.i_value = v;
    bus.i_prev = p;
    bus.i_next = n;
    e.disp = (r || mstate == 0) ? 4'd0 : hist[midx];
    if (r) begin
      hist.delete();
      midx = 0;
      mstate = 0;
      mmax = 4'd0;
    end else if (d) begin
      hist.push_front(v);
      if (hist.size() > DEPTH) void'(hist.pop_back());
      midx = 0;
      mstate = 1;
      if (v > mmax) mmax = v;
    end else if (p && !n) begin
      if (mstate == 1 && hist.size() >= 2) begin
        midx = 1;
        mstate = 2;
      end else if (mstate == 2 && midx < hist.size() - 1) begin
        midx++;
      end
    end else if (n && !p) begin
      if (mstate == 2) begin
        midx--;
        if (midx == 0) mstate = 1;
      end
    end
    e.idx = 3'(midx);
    e.cnt = 4'(hist.size());
    e.empty = (hist.size() == 0);
`ifdef RNG_HISTORY_MAX_EN
    e.max = mmax;
`else
    e.max = 4'd0;
`endif
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("display", 32'(bus.o_display), 32'(got.disp));
    chk("index",   32'(bus.o_index),   32'(got.idx));
    chk("count",   32'(bus.o_count),   32'(got.cnt));
    chk("empty",   32'(bus.o_empty),   32'(got.empty));
    chk("max",     32'(bus.o_max),     32'(got.max));
  endtask

  task automatic push(input logic [3:0] v);
    step(1'b0, 1'b1, v, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic prev();
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
  endtask

  task automatic next();
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic reset();
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_value = '0;
    bus.i_done = 1'b0;
    bus.i_prev = 1'b0;
    bus.i_next = 1'b0;

    // Reset and empty-state browsing
    reset();
    reset();
    chk("rst_empty", 32'(bus.o_empty), 32'd1);
    chk("rst_display", 32'(bus.o_display), 32'd0);
    prev();
    next();
    idle();
    chk("empty_idx", 32'(bus.o_index), 32'd0);
    chk("empty_flag", 32'(bus.o_empty), 32'd1);

    // Push then browse
    push(4'd3);
    push(4'd7);
    push(4'd12);
    idle();
    chk("live_display", 32'(bus.o_display), 32'd12);
    chk("live_count", 32'(bus.o_count), 32'd3);
    prev();
    prev();
    prev();
    idle();
    chk("browse_idx_sat", 32'(bus.o_index), 32'd2);
    chk("browse_oldest", 32'(bus.o_display), 32'd3);
    next();
    next();
    idle();
    chk("back_live", 32'(bus.o_display), 32'd12);
    chk("back_idx", 32'(bus.o_index), 32'd0);

    // Collision: push beats a same-cycle prev
    prev();
    prev();
    step(1'b0, 1'b1, 4'd5, 1'b1, 1'b0);
    idle();
    chk("coll_idx", 32'(bus.o_index), 32'd0);
    chk("coll_display", 32'(bus.o_display), 32'd5);

    // prev and next together: no change
    prev();
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    chk("both_idx", 32'(bus.o_index), 32'd1);

    // Wrap / overwrite
    reset();
    for (int i = 1; i <= 10; i++) push(4'(i));
    chk("wrap_count", 32'(bus.o_count), 32'd8);
    for (int i = 0; i < 7; i++) prev();
    idle();
    chk("wrap_oldest", 32'(bus.o_display), 32'd3);
    prev();
    idle();
    chk("wrap_hold", 32'(bus.o_index), 32'd7);

    // Mid-operation reset
    reset();
    push(4'd1);
    push(4'd2);
    push(4'd3);
    push(4'd4);
    prev();
    prev();
    reset();
    chk("midrst_count", 32'(bus.o_count), 32'd0);
    chk("midrst_display", 32'(bus.o_display), 32'd0);
    chk("midrst_idx", 32'(bus.o_index), 32'd0);
    push(4'd9);
    chk("midrst_push", 32'(bus.o_count), 32'd1);

    // Running maximum
    reset();
`ifdef RNG_HISTORY_MAX_EN
    push(4'd9);  chk("max_a", 32'(bus.o_max), 32'd9);
    push(4'd4);  chk("max_b", 32'(bus.o_max), 32'd9);
    push(4'd15); chk("max_c", 32'(bus.o_max), 32'd15);
    push(4'd2);  chk("max_d", 32'(bus.o_max), 32'd15);
`else
    push(4'd9);  chk("max_a", 32'(bus.o_max), 32'd0);
    push(4'd4);  chk("max_b", 32'(bus.o_max), 32'd0);
    push(4'd15); chk("max_c", 32'(bus.o_max), 32'd0);
    push(4'd2);  chk("max_d", 32'(bus.o_max), 32'd0);
`endif

    // Random mix against the queue model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 3) == 0,
           4'($urandom_range(0, 15)),
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
